dcache_ctrl: RTL

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_ctrl_if.sv | 27 ++
 rtl/dcache_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/dcache_ctrl_if.sv
// CPU-side request/response and memory-side word-transfer signals of the data cache.
// The slave modport is the cache's view; the master modport is the pipeline/memory view.
interface dcache_ctrl_if;
    logic        rd_req;
    logic        wr_req;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [31:0] rd_data;
    logic        miss;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic        mem_gnt;

    modport slave (
        input  rd_req, wr_req, addr, wr_data, wr_be, mem_rd_data, mem_gnt,
        output rd_data, miss, mem_rd_req, mem_wr_req, mem_addr, mem_wr_data
    );

    modport master (
        output rd_req, wr_req, addr, wr_data, wr_be, mem_rd_data, mem_gnt,
        input  rd_data, miss, mem_rd_req, mem_wr_req, mem_addr, mem_wr_data
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back / write-allocate data cache controller.
// Misses stall the pipeline while dirty victims are written back and the line is refilled word by word.
module dcache_ctrl #(
    parameter int LINES = 8,
    parameter int WORDS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    dcache_ctrl_if.slave bus
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(WORDS - 1);
    localparam logic [OFF_W-1:0] CNT_ONE  = OFF_W'(1);

    typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

    state_t           state, state_nxt;
    logic [OFF_W-1:0] cnt, cnt_nxt;

    logic [LINES-1:0] valid;
    logic [LINES-1:0] dirty;
    logic [TAG_W-1:0] tags [LINES];
    logic [31:0]      data [LINES][WORDS];

    logic [OFF_W-1:0] offset;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic             req;
    logic             hit;
    logic             last;
    logic             store_hit;
    logic             fill_done;
    logic             unused_addr_lsb;

    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;

    assign offset          = bus.addr[OFF_W+1:2];
    assign index           = bus.addr[IDX_W+OFF_W+1:OFF_W+2];
    assign tag             = bus.addr[31:32-TAG_W];
    assign unused_addr_lsb = &{1'b0, bus.addr[1:0]};

    assign req       = bus.rd_req | bus.wr_req;
    assign hit       = req && valid[index] && (tags[index] == tag);
    assign last      = (cnt == CNT_LAST);
    // A simultaneous read+write request is a store, so only wr_req decides the write path.
    assign store_hit = (state == IDLE) && hit && bus.wr_req;
    assign fill_done = (state == FILL) && bus.mem_gnt && last;

    assign bus.miss        = (req && !hit) || (state != IDLE);
    assign bus.rd_data     = data[index][offset];
    assign bus.mem_rd_req  = mem_rd_req;
    assign bus.mem_wr_req  = mem_wr_req;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wr_data = mem_wr_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        case (state)
            IDLE: begin
                if (req && !hit) begin
                    cnt_nxt   = '0;
                    state_nxt = (valid[index] && dirty[index]) ? WB : FILL;
                end
            end
            WB: begin
                mem_wr_req  = 1'b1;
                mem_addr    = {tags[index], index, cnt, 2'b00};
                mem_wr_data = data[index][cnt];
                if (bus.mem_gnt) begin
                    cnt_nxt = last ? '0 : cnt + CNT_ONE;
                    if (last) state_nxt = FILL;
                end
            end
            FILL: begin
                // The held CPU request supplies the refill tag; it is never re-sampled here.
                mem_rd_req = 1'b1;
                mem_addr   = {tag, index, cnt, 2'b00};
                if (bus.mem_gnt) begin
                    cnt_nxt = last ? '0 : cnt + CNT_ONE;
                    if (last) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (store_hit) dirty[index] <= 1'b1;
            if (fill_done) begin
                valid[index] <= 1'b1;
                dirty[index] <= 1'b0;
            end
        end
    end

    // Tag and data arrays carry no reset; a cleared valid bit makes their contents irrelevant.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (store_hit) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.wr_be[b]) data[index][offset][8*b +: 8] <= bus.wr_data[8*b +: 8];
                end
            end
            if ((state == FILL) && bus.mem_gnt) data[index][cnt] <= bus.mem_rd_data;
            if (fill_done) tags[index] <= tag;
        end
    end
endmodule
